// File: rtl/mm_pkg.sv
// Shared types for the MinMax tracker stream driver: FSM states, sample FIFO entry, tracker init values.
// No logic beyond two small unsigned compare helpers used by the shadow tracker.
package mm_pkg;
    localparam int MM_W = 4;
    localparam logic [MM_W-1:0] MM_MIN_INIT = {MM_W{1'b1}};
    localparam logic [MM_W-1:0] MM_MAX_INIT = '0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        RD_MIN,
        CAP_MIN,
        CAP_MAX,
        RESP
    } mm_state_t;

    typedef struct packed {
        logic            last;
        logic [MM_W-1:0] data;
    } mm_entry_t;

    function automatic logic [MM_W-1:0] mm_umin(input logic [MM_W-1:0] a, input logic [MM_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [MM_W-1:0] mm_umax(input logic [MM_W-1:0] a, input logic [MM_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/mm_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; read data is the head entry (zero-cycle read).
// Backpressure: o_wr_rdy = !full; a write on a full FIFO is taken only together with a read.
module mm_sample_fifo
    import mm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clock,
    input  logic      i_reset_n,
    input  logic      i_wr_vld,
    input  mm_entry_t i_wr_dat,
    output logic      o_wr_rdy,
    input  logic      i_rd_en,
    output logic      o_rd_vld,
    output mm_entry_t o_rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mm_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd     = i_rd_en & ~w_empty;
    assign w_wr     = i_wr_vld & (~w_full | w_rd);
    assign o_wr_rdy = ~w_full;
    assign o_rd_vld = ~w_empty;
    assign o_rd_dat = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mm_stream_driver.sv
// Buffers host samples, clears the MinMax tracker, streams a burst into it, reads min/max back and checks them
// against a local shadow. Result is valid N+5 cycles after the first write; result held until res_ready.
module mm_stream_driver
    import mm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = MM_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         mm_clr,
    output logic         mm_ld,
    output logic [W-1:0] mm_data,
    output logic         mm_sel,
    input  logic [W-1:0] mm_q,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_min,
    output logic [W-1:0] res_max,
    output logic         res_err,
    output logic         busy
);
    mm_state_t    r_state;
    mm_state_t    w_next;
    logic [W-1:0] r_sh_min;
    logic [W-1:0] r_sh_max;
    logic [W-1:0] r_res_min;
    logic [W-1:0] r_res_max;
    logic         r_res_err;
    logic         r_res_valid;

    logic         w_wr;
    mm_entry_t    w_wr_dat;
    logic         w_rd_vld;
    mm_entry_t    w_rd_dat;
    logic         w_pop;
    logic         w_clr;
    logic         w_ld;
    logic         w_sel;
    logic [W-1:0] w_data;

    assign w_wr     = in_valid & in_ready;
    assign w_wr_dat = '{last: in_last, data: in_data};

    mm_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_wr_vld  (w_wr),
        .i_wr_dat  (w_wr_dat),
        .o_wr_rdy  (in_ready),
        .i_rd_en   (w_pop),
        .o_rd_vld  (w_rd_vld),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mm_q is registered in the tracker, so each capture uses the select driven one state earlier.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_ld   = 1'b0;
        w_sel  = 1'b0;
        w_pop  = 1'b0;
        w_data = '0;
        case (r_state)
            IDLE: begin
                if (w_rd_vld) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                w_clr  = 1'b1;
                w_next = FEED;
            end
            FEED: begin
                if (w_rd_vld) begin
                    w_pop  = 1'b1;
                    w_ld   = 1'b1;
                    w_data = w_rd_dat.data;
                    if (w_rd_dat.last) begin
                        w_next = RD_MIN;
                    end
                end
            end
            RD_MIN: begin
                w_next = CAP_MIN;
            end
            CAP_MIN: begin
                w_sel  = 1'b1;
                w_next = CAP_MAX;
            end
            CAP_MAX: begin
                w_sel  = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                if (r_res_valid && res_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_min    <= MM_MIN_INIT;
            r_sh_max    <= MM_MAX_INIT;
            r_res_min   <= '0;
            r_res_max   <= '0;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_clr) begin
                r_sh_min <= MM_MIN_INIT;
                r_sh_max <= MM_MAX_INIT;
            end else if (w_ld) begin
                r_sh_min <= mm_umin(r_sh_min, w_data);
                r_sh_max <= mm_umax(r_sh_max, w_data);
            end
            if (r_state == CAP_MIN) begin
                r_res_min <= mm_q;
            end
            if (r_state == CAP_MAX) begin
                r_res_max   <= mm_q;
                r_res_err   <= (r_res_min != r_sh_min) | (mm_q != r_sh_max);
                r_res_valid <= 1'b1;
            end else if (r_state == RESP && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign mm_clr    = w_clr;
    assign mm_ld     = w_ld;
    assign mm_data   = w_data;
    assign mm_sel    = w_sel;
    assign res_valid = r_res_valid;
    assign res_min   = r_res_min;
    assign res_max   = r_res_max;
    assign res_err   = r_res_err;
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mm_stream_driver.sv
// Bench for mm_stream_driver: behavioural tracker model on the mm_* pins, burst reference computed from the sample list.
module tb_mm_stream_driver;
    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       in_valid  = 1'b0;
    logic [3:0] in_data   = 4'h0;
    logic       in_last   = 1'b0;
    logic       res_ready = 1'b1;
    logic [3:0] mm_q      = 4'h0;
    logic       in_ready;
    logic       mm_clr;
    logic       mm_ld;
    logic [3:0] mm_data;
    logic       mm_sel;
    logic       res_valid;
    logic [3:0] res_min;
    logic [3:0] res_max;
    logic       res_err;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mm_stream_driver #(.DEPTH(4), .W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .mm_clr    (mm_clr),
        .mm_ld     (mm_ld),
        .mm_data   (mm_data),
        .mm_sel    (mm_sel),
        .mm_q      (mm_q),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_min   (res_min),
        .res_max   (res_max),
        .res_err   (res_err),
        .busy      (busy)
    );

    // Tracker model: registered report of whichever extreme mm_sel picks; fault_min forces a bad minimum.
    logic [3:0] t_min     = 4'hF;
    logic [3:0] t_max     = 4'h0;
    logic       fault_min = 1'b0;
    always @(posedge clock) begin
        if (mm_clr) begin
            t_min <= 4'hF;
            t_max <= 4'h0;
        end else if (mm_ld) begin
            if (mm_data < t_min) t_min <= mm_data;
            if (mm_data > t_max) t_max <= mm_data;
        end
        mm_q <= mm_sel ? t_max : (fault_min ? 4'd3 : t_min);
    end

    int         cyc = 0;
    int         clr_total = 0;
    int         ld_total = 0;
    int         overlap = 0;
    int         rv_rise = 0;
    logic       rv_prev = 1'b0;
    logic [3:0] ld_log [0:1023];
    int         ld_cyc [0:1023];
    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (mm_clr) clr_total++;
        if (mm_clr && mm_ld) overlap++;
        if (mm_ld) begin
            ld_log[ld_total % 1024] = mm_data;
            ld_cyc[ld_total % 1024] = cyc;
            ld_total++;
        end
        if (res_valid && !rv_prev) rv_rise = cyc;
        rv_prev = res_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    logic [3:0] bd [0:15];
    int         blen;
    int         clr_base;
    int         ld_base;
    int         first_wr;
    int         last_wr;

    task automatic new_burst();
        clr_base = clr_total;
        ld_base  = ld_total;
    endtask

    task automatic push(input logic [3:0] d, input logic l);
        int t = 0;
        step();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) chk("push_timeout", in_ready, 1);
        last_wr = cyc + 1;
    endtask

    task automatic idle();
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res();
        int t = 0;
        while (!res_valid && t < 300) begin
            step();
            t++;
        end
        chk("res_timeout", res_valid, 1);
    endtask

    // Reference: true extremes of the sample list; the tracker's reports decide res_min/res_max.
    task automatic check_burst();
        logic [3:0] rmin = 4'hF;
        logic [3:0] rmax = 4'h0;
        logic [3:0] emin;
        for (int i = 0; i < blen; i++) begin
            if (bd[i] < rmin) rmin = bd[i];
            if (bd[i] > rmax) rmax = bd[i];
        end
        emin = fault_min ? 4'd3 : rmin;
        chk("res_min", res_min, emin);
        chk("res_max", res_max, rmax);
        chk("res_err", res_err, (emin != rmin) ? 1 : 0);
        chk("clr_count", clr_total - clr_base, 1);
        chk("ld_count", ld_total - ld_base, blen);
        for (int i = 0; i < blen; i++) begin
            chk("ld_data", ld_log[(ld_base + i) % 1024], bd[i]);
        end
    endtask

    task automatic run_burst(input int gap_max);
        int g;
        new_burst();
        for (int i = 0; i < blen; i++) begin
            push(bd[i], (i == blen - 1));
            if (i == 0) first_wr = last_wr;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                idle();
                repeat (g - 1) step();
            end
        end
        idle();
        wait_res();
        check_burst();
        step();
    endtask

    logic [3:0] h_min;
    logic [3:0] h_max;
    logic       h_err;
    int         unstable;
    int         nacc;
    logic [3:0] bb [0:5];
    int         t;

    initial begin
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mm_clr", mm_clr, 0);
        chk("rst_mm_ld", mm_ld, 0);
        chk("rst_mm_sel", mm_sel, 0);
        chk("rst_mm_data", mm_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_minmax", {res_min, res_max, 3'b0, res_err}, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        step();

        // Basic burst and latency
        bd[0] = 4'd5; bd[1] = 4'd2; bd[2] = 4'd9; bd[3] = 4'd7; blen = 4;
        run_burst(0);
        chk("latency", rv_rise - first_wr, blen + 5);

        bd[0] = 4'hA; blen = 1;
        run_burst(0);
        bd[0] = 4'hF; bd[1] = 4'hF; blen = 2;
        run_burst(0);
        bd[0] = 4'h0; blen = 1;
        run_burst(0);

        fault_min = 1'b1;
        bd[0] = 4'd4; bd[1] = 4'd6; blen = 2;
        run_burst(0);
        fault_min = 1'b0;

        // Host gap: FEED must sit with mm_ld low while the FIFO is empty
        bd[0] = 4'd8; bd[1] = 4'd1; blen = 2;
        new_burst();
        push(bd[0], 1'b0);
        idle();
        t = 0;
        while (ld_total == ld_base && t < 50) begin
            step();
            t++;
        end
        chk("gap_first_ld", ld_total - ld_base, 1);
        step();
        step();
        push(bd[1], 1'b1);
        idle();
        wait_res();
        check_burst();
        chk("gap_bubbles", ld_cyc[(ld_base + 1) % 1024] - ld_cyc[ld_base % 1024] - 1, 3);
        step();

        // Result backpressure with a second burst piling up in the FIFO
        res_ready = 1'b0;
        bd[0] = 4'd1; bd[1] = 4'hE; blen = 2;
        new_burst();
        push(bd[0], 1'b0);
        push(bd[1], 1'b1);
        idle();
        wait_res();
        check_burst();
        h_min = res_min;
        h_max = res_max;
        h_err = res_err;
        for (int i = 0; i < 6; i++) bb[i] = 4'($urandom_range(0, 15));
        new_burst();
        unstable = 0;
        nacc = 0;
        repeat (10) begin
            step();
            if (res_min !== h_min || res_max !== h_max || res_err !== h_err || res_valid !== 1'b1) unstable++;
            in_valid = 1'b1;
            in_data  = bb[nacc];
            in_last  = (nacc == 5);
            if (in_ready) nacc++;
        end
        chk("bp_accepted", nacc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("hold_stable", unstable, 0);
        chk("hold_no_clr", clr_total - clr_base, 0);
        step();
        res_ready = 1'b1;
        step();
        chk("hs_idle_clr", mm_clr, 0);
        chk("hs_idle_busy", busy, 0);
        chk("hs_valid_drop", res_valid, 0);
        step();
        chk("hs_clear", mm_clr, 1);
        for (int i = nacc; i < 6; i++) push(bb[i], (i == 5));
        idle();
        for (int i = 0; i < 6; i++) bd[i] = bb[i];
        blen = 6;
        wait_res();
        check_burst();
        step();

        // Randomized bursts with host gaps
        for (int k = 0; k < 6; k++) begin
            blen = $urandom_range(1, 8);
            for (int i = 0; i < blen; i++) bd[i] = 4'($urandom_range(0, 15));
            run_burst(2);
        end

        // Asynchronous reset in the middle of FEED
        push(4'd7, 1'b0);
        push(4'd1, 1'b0);
        push(4'd12, 1'b0);
        push(4'd4, 1'b1);
        idle();
        t = 0;
        while (!mm_ld && t < 50) begin
            step();
            t++;
        end
        chk("pre_reset_ld", mm_ld, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_mm_ld", mm_ld, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_res", {res_valid, res_err, res_min, res_max}, 0);
        step();
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_in_ready", in_ready, 1);
        bd[0] = 4'd3; blen = 1;
        run_burst(0);

        chk("clr_ld_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
